// File: rtl/udp_probe_tap.sv
// udp_probe_tap
// Passive tap on the UDP byte stream (UDP header + payload, one byte per
// beat) that feeds the on-chip logic analyzer. It parses the 8-byte UDP
// header, fires a one-cycle trigger when the destination port matches and
// exposes the current byte and its frame index. The stream is never stalled.
//
// Parameters:
//   MATCH_PORT   destination port that fires the trigger (default 8080)
//   MATCH_ANY    1 = trigger on every complete header regardless of port
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_valid     byte strobe qualifying rx_data/rx_sof/rx_eof
//   rx_data      stream byte
//   rx_sof       first byte of the UDP header
//   rx_eof       last byte of the frame
//   probe0       trigger pulse (one cycle after header byte 7 on match)
//   probe1       registered data byte
//   probe2       registered byte index within the frame (saturating)
//   frame_active high from the cycle after sof through the eof beat
//   len_err      (UDP_PROBE_TAP_LEN_CHECK_EN only) pulses when the frame
//                byte count differs from the UDP length field
//
// Optional feature macro: UDP_PROBE_TAP_LEN_CHECK_EN
module udp_probe_tap #(
  parameter logic [15:0] MATCH_PORT = 16'd8080,
  parameter int          MATCH_ANY  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_sof,
  input  logic        rx_eof,
  output logic        probe0,
  output logic [7:0]  probe1,
  output logic [15:0] probe2,
  output logic        frame_active
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
  ,
  output logic        len_err
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] idx_r;        // index the next non-sof beat will carry
  logic [15:0] idx_s;
  logic [15:0] beat_idx_s;   // index of the beat currently on the bus
  logic [15:0] dst_r;
  logic        sof_s;
  logic        eof_s;
  logic        hdr_last_s;
  logic        match_s;
  logic        trig_s;
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
  logic [15:0] len_r;
  logic [16:0] count_s;
  logic        len_chk_s;
`endif

  // Qualified strobes; sof has priority over a coincident eof.
  always_comb begin
    sof_s = rx_valid & rx_sof;
    eof_s = rx_valid & rx_eof & ~rx_sof;
  end

  // Index of the current beat: 0 on sof and outside a frame, else the counter.
  always_comb begin
    beat_idx_s = 16'h0000;
    if (sof_s) begin
      beat_idx_s = 16'h0000;
    end else if (state_r == IDLE) begin
      beat_idx_s = 16'h0000;
    end else begin
      beat_idx_s = idx_r;
    end
  end

  // Header completion and port match decode.
  always_comb begin
    hdr_last_s = rx_valid & ~rx_sof & (state_r == HDR) & (beat_idx_s == 16'd7);
    match_s    = (MATCH_ANY != 0) || (dst_r == MATCH_PORT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a new sof abandons any frame in progress.
  always_comb begin
    state_s = state_r;
    if (sof_s) begin
      state_s = HDR;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        HDR: begin
          if (hdr_last_s) begin
            // An 8-byte frame ending on byte 7 still completes its header.
            if (eof_s) begin
              state_s = IDLE;
            end else if (match_s) begin
              state_s = PAYLOAD;
            end else begin
              state_s = DROP;
            end
          end else if (eof_s) begin
            state_s = IDLE;
          end else begin
            state_s = HDR;
          end
        end
        PAYLOAD, DROP: begin
          if (eof_s) begin
            state_s = IDLE;
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM output decode: trigger and (optionally) length mismatch.
  always_comb begin
    trig_s = hdr_last_s & match_s;
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
    count_s   = {1'b0, beat_idx_s} + 17'd1;
    len_chk_s = eof_s & ((state_r == PAYLOAD) || (state_r == DROP)) &
                (count_s != {1'b0, len_r});
`endif
  end

  // Next value of the beat counter: restart outside frames, saturate at FFFF.
  always_comb begin
    idx_s = idx_r;
    if (rx_valid) begin
      if (state_s == IDLE) begin
        idx_s = 16'h0000;
      end else if (beat_idx_s == 16'hFFFF) begin
        idx_s = 16'hFFFF;
      end else begin
        idx_s = beat_idx_s + 16'd1;
      end
    end else begin
      idx_s = idx_r;
    end
  end

  // Beat counter and header field capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= 16'h0000;
      dst_r <= 16'h0000;
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
      len_r <= 16'h0000;
`endif
    end else begin
      idx_r <= idx_s;
      if (sof_s) begin
        dst_r <= 16'h0000;
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
        len_r <= 16'h0000;
`endif
      end else if (rx_valid && (state_r == HDR)) begin
        case (beat_idx_s)
          16'd2:   dst_r[15:8] <= rx_data;
          16'd3:   dst_r[7:0]  <= rx_data;
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
          16'd4:   len_r[15:8] <= rx_data;
          16'd5:   len_r[7:0]  <= rx_data;
`endif
          default: dst_r       <= dst_r;
        endcase
      end
    end
  end

  // Registered probe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe0       <= 1'b0;
      probe1       <= 8'h00;
      probe2       <= 16'h0000;
      frame_active <= 1'b0;
    end else begin
      probe0       <= trig_s;
      frame_active <= (state_s != IDLE);
      if (rx_valid) begin
        probe1 <= rx_data;
        probe2 <= beat_idx_s;
      end
    end
  end

`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
  // Length-error pulse, aligned with the eof beat's index update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err <= 1'b0;
    end else begin
      len_err <= len_chk_s;
    end
  end
`endif

endmodule

// File: tb/tb_udp_probe_tap.sv
// Directed self-checking bench for udp_probe_tap. Two instances share the
// stream: dut (MATCH_PORT 8080) and dut_any (MATCH_ANY=1). Inputs change on
// the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_udp_probe_tap;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_sof   = 1'b0;
  logic        rx_eof   = 1'b0;
  logic        p0, a_p0, fa, a_fa;
  logic [7:0]  p1, a_p1;
  logic [15:0] p2, a_p2;
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
  logic        le, a_le;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] fm[$];    // matching frame, length field 12
  logic [7:0] fn[$];    // dst 0x0035
  logic [7:0] f14[$];   // matching header, 14 bytes
  logic [7:0] fs[$];    // 5-byte short frame

  always #5 clk = ~clk;

  udp_probe_tap dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .probe0(p0), .probe1(p1),
    .probe2(p2), .frame_active(fa)
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
    , .len_err(le)
`endif
  );

  udp_probe_tap #(.MATCH_ANY(1)) dut_any (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .probe0(a_p0), .probe1(a_p1),
    .probe2(a_p2), .frame_active(a_fa)
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
    , .len_err(a_le)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic e);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    rx_sof   = s;
    rx_eof   = e;
    @(posedge clk);
    #1;
  endtask

  // One valid beat followed by checks of every probe.
  task automatic beat(input logic [7:0] d, input logic s, input logic e,
                      input logic [15:0] ei, input logic et, input logic eta,
                      input logic efa, input logic ele);
    drive(d, 1'b1, s, e);
    chk("probe1", {24'h0, p1}, {24'h0, d});
    chk("probe2", {16'h0, p2}, {16'h0, ei});
    chk("probe0", {31'h0, p0}, {31'h0, et});
    chk("any_probe0", {31'h0, a_p0}, {31'h0, eta});
    chk("frame_active", {31'h0, fa}, {31'h0, efa});
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
    chk("len_err", {31'h0, le}, {31'h0, ele});
`endif
  endtask

  // Invalid cycles with junk on data/sof/eof: everything must hold.
  task automatic idle(input int n, input logic [7:0] ed, input logic [15:0] ei, input logic efa);
    for (int k = 0; k < n; k++) begin
      drive(8'hA5, 1'b0, 1'b1, 1'b1);
      chk("gap_probe1", {24'h0, p1}, {24'h0, ed});
      chk("gap_probe2", {16'h0, p2}, {16'h0, ei});
      chk("gap_probe0", {30'h0, p0, a_p0}, 32'h0);
      chk("gap_frame_active", {31'h0, fa}, {31'h0, efa});
    end
  endtask

  // Full frame from sof to eof; trigger expected on index 7 when m/ma set.
  task automatic frame(input logic [7:0] b[$], input int gap, input logic m,
                       input logic ma, input logic le_end);
    logic last;
    for (int i = 0; i < b.size(); i++) begin
      last = (i == b.size() - 1);
      beat(b[i], (i == 0), last, i[15:0], m && (i == 7), ma && (i == 7),
           !last, le_end && last);
      if (gap > 0 && !last) idle(gap, b[i], i[15:0], 1'b1);
    end
  endtask

  initial begin
    fm  = '{8'h04, 8'hD2, 8'h1F, 8'h90, 8'h00, 8'h0C, 8'h00, 8'h00,
            8'hAA, 8'hBB, 8'hCC, 8'hDD};
    fn  = '{8'h04, 8'hD2, 8'h00, 8'h35, 8'h00, 8'h0C, 8'h00, 8'h00,
            8'hAA, 8'hBB, 8'hCC, 8'hDD};
    f14 = '{8'h04, 8'hD2, 8'h1F, 8'h90, 8'h00, 8'h0C, 8'h00, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fs  = '{8'h04, 8'hD2, 8'h1F, 8'h90, 8'h00};

    // Reset held with random traffic: all outputs stay zero.
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), 1'b1, 1'($urandom), 1'($urandom));
      chk("rst_outputs", {p0, fa, p1, p2}, 32'h0);
    end
    rst_n = 1'b1;

    // Released mid-stream without sof: data echoes, index 0, no parsing.
    for (int i = 0; i < 9; i++) begin
      beat(8'h10 + i[7:0], 1'b0, (i == 4), 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Matching frame, contiguous.
    frame(fm, 0, 1'b1, 1'b1, 1'b0);
    idle(2, 8'hDD, 16'd11, 1'b0);

    // Non-matching port: only the MATCH_ANY instance triggers.
    frame(fn, 0, 1'b0, 1'b1, 1'b0);

    // Matching frame with 3-cycle gaps between every byte.
    frame(fm, 3, 1'b1, 1'b1, 1'b0);

    // Short 5-byte frame, then a normal frame.
    frame(fs, 0, 1'b0, 1'b0, 1'b0);
    idle(1, 8'h00, 16'd4, 1'b0);
    frame(fm, 0, 1'b1, 1'b1, 1'b0);

    // Restart: new sof at payload index 6 (beat 14).
    for (int i = 0; i < 14; i++) begin
      beat(f14[i], (i == 0), 1'b0, i[15:0], (i == 7), (i == 7), 1'b1, 1'b0);
    end
    frame(fm, 0, 1'b1, 1'b1, 1'b0);

    // sof and eof together: sof wins, frame proceeds from index 1.
    beat(fm[0], 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 12; i++) begin
      beat(fm[i], 1'b0, (i == 11), i[15:0], (i == 7), (i == 7), (i != 11), 1'b0);
    end

    // Length check: 14-byte frame against length field 12.
    frame(f14, 0, 1'b1, 1'b1, 1'b1);
    idle(1, 8'h66, 16'd13, 1'b0);
`ifdef UDP_PROBE_TAP_LEN_CHECK_EN
    chk("len_err_after", {31'h0, le}, 32'h0);
`endif

    // Index saturation at FFFF (header bytes 1..7 give dst 0x0203, len 0x0405).
    beat(8'h00, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 65540; i++) begin
      drive(i[7:0], 1'b1, 1'b0, 1'b0);
    end
    chk("sat_probe2", {16'h0, p2}, 32'h0000FFFF);
    beat(8'hEE, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame.
    beat(fm[0], 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(fm[1], 1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(fm[2], 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {p0, fa, p1, p2}, 32'h0);
    #2;
    rst_n = 1'b1;
    // Continuing the old frame without sof must not parse.
    for (int i = 3; i < 12; i++) begin
      beat(fm[i], 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    frame(fm, 0, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_probe_tap.md
Name: udp_probe_tap

Overview:
- Upstream feeder for the on-chip logic-analyzer instance in the UDP example.
- Passively taps the UDP byte stream (UDP header + payload, one byte per beat) and parses the 8-byte UDP header.
- Drives the analyzer's three probes:
  - probe0: 1-bit trigger pulse on destination-port match.
  - probe1: 8-bit registered data byte.
  - probe2: 16-bit byte index within the frame.
- Never back-pressures the stream.

Parameters:
- MATCH_PORT, 16'd8080, UDP destination port that fires the trigger.
- MATCH_ANY, 0, 1 = trigger on every header-complete frame regardless of port.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  byte strobe; rx_data/rx_sof/rx_eof are meaningful only when high.
- rx_data  input  8  stream byte.
- rx_sof  input  1  first byte of UDP header (qualified by rx_valid).
- rx_eof  input  1  last byte of frame (qualified by rx_valid).
- probe0  output  1  trigger pulse to analyzer.
- probe1  output  8  registered data byte.
- probe2  output  16  registered byte index.
- frame_active  output  1  high from accepted sof byte through eof byte.

Behaviour:
- Reset (async assert, sync release): probe0=0, probe1=8'h00, probe2=16'h0000, frame_active=0, FSM=IDLE, counters and captured fields 0.
- All outputs are registered, with 1-cycle latency from the accepted input beat.
- probe1: loads rx_data on every rx_valid beat (any state); holds otherwise.
- probe2: loads the index of the current beat on every rx_valid beat.
  - sof beat is index 0, then +1 per valid beat.
  - Saturates at 16'hFFFF (no wrap).
  - Holds when rx_valid=0.
- FSM states IDLE, HDR, PAYLOAD, DROP:
  - IDLE: rx_valid&rx_sof -> HDR, idx=1 next. A valid beat without sof is ignored for parsing (probe1/probe2 still update; probe2 shows 0).
  - HDR: capture dst port (byte2 = MSB, byte3 = LSB) and UDP length (byte4 MSB, byte5 LSB).
    - On the byte7 beat: if match -> PAYLOAD, else -> DROP.
    - match = MATCH_ANY | (dst_port == MATCH_PORT).
  - PAYLOAD / DROP: remain until rx_valid&rx_eof -> IDLE.
- Trigger: probe0 = single 1-cycle pulse, registered on the cycle after the byte7 beat, when match is true. At most one pulse per frame.
- frame_active: set on the cycle after the sof beat; cleared on the cycle after the eof beat.
- Boundary cases:
  - eof in HDR (frame shorter than 8 bytes) -> IDLE, no trigger.
  - eof and sof on the same beat: sof wins (treated as a 1-byte frame end plus a restart is not supported). The FSM enters HDR and idx restarts at 0.
  - sof while in HDR/PAYLOAD/DROP: abandon the current frame, restart at HDR, index 0, no trigger for the abandoned frame.
  - rx_valid gaps of any length are allowed in any state; state and counters hold.
  - Reset mid-frame: immediate return to reset values. The next frame is parsed only from a fresh sof.
  - rx_sof/rx_eof while rx_valid=0: ignored.

Optional Feature:
- Macro: UDP_PROBE_TAP_LEN_CHECK_EN.
- Defined:
  - Adds output len_err (1 bit, reset 0).
  - On the eof beat in PAYLOAD or DROP, compares the beat count (index of eof + 1, 17-bit, saturating) with the captured UDP length field.
  - On mismatch, len_err pulses 1 cycle, aligned with the probe2 update of the eof beat.
  - No pulse for frames aborted in HDR or by a new sof.
- Undefined: port absent, no comparator or length register; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with random stream -> all outputs 0. Release mid-stream without sof -> no trigger, frame_active stays 0.
- Matching frame:
  - Stimulus: header 04 D2 1F 90 00 0C 00 00 + 4 payload bytes, contiguous (default MATCH_PORT).
  - Expect: probe0 pulses exactly once, 1 cycle after byte7. probe2 sequence 0..11. probe1 echoes each byte 1 cycle later. frame_active spans 12 cycles.
- Non-matching port: same frame with dst 0x0035 -> no probe0 pulse; probe1/probe2 still track. Repeat with MATCH_ANY=1 -> pulse present.
- Gaps and short frame:
  - Matching frame with rx_valid low for 3 cycles between every byte -> same probe2 sequence, single pulse.
  - 5-byte frame with eof at byte4 -> no pulse, FSM back to IDLE, next frame parses normally.
- Restart mid-frame: new sof at payload index 6 -> probe2 returns to 0, new frame triggers once, old frame gives no extra pulse.
- With UDP_PROBE_TAP_LEN_CHECK_EN:
  - Length field 0x000C, 12 bytes -> len_err stays 0.
  - Same header with 14 bytes -> one len_err pulse aligned with the eof index update.
